// File: rtl/mips32_mem_arbiter_if.sv
// Requester and memory-side bus for the unified-memory arbiter.
// slave: arbiter view, master: requester/memory view.
interface mips32_mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic          dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for fetch, data-memory and debug requesters,
// with registered memory command, 2-cycle read return, debug lock and fetch starvation guard.
module mips32_mem_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                halted,
    mips32_mem_arbiter_if.slave bus,
    output logic                fetch_stall
);
    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_DM  = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    logic          if_gnt_c, dm_gnt_c, dbg_gnt_c, any_gnt;
    logic          if_act, boost;
    logic          lock_q;
    logic [SW-1:0] starve_cnt;

    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    owner_t        win_owner;

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          tag1_valid, tag1_read, tag2_valid, tag2_read;
    owner_t        tag1_owner, tag2_owner;

    assign if_act  = bus.if_req & ~halted;
    assign boost   = (starve_cnt >= SW'(STARVE_LIMIT));
    assign any_gnt = if_gnt_c | dm_gnt_c | dbg_gnt_c;

    // The held lock is the registered flag, so the cycle in which dbg drops its
    // request still excludes the other requesters; the lock releases at that edge.
    always_comb begin
        if_gnt_c  = 1'b0;
        dm_gnt_c  = 1'b0;
        dbg_gnt_c = 1'b0;
        if (!rst) begin
            if (lock_q || bus.dbg_req) dbg_gnt_c = bus.dbg_req;
            else if (boost && if_act)  if_gnt_c  = 1'b1;
            else if (bus.dm_req)       dm_gnt_c  = 1'b1;
            else if (if_act)           if_gnt_c  = 1'b1;
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = bus.if_addr;
        win_wdata = mem_wdata_q;
        win_owner = OWN_IF;
        if (dbg_gnt_c) begin
            win_we    = bus.dbg_we;
            win_addr  = bus.dbg_addr;
            win_wdata = bus.dbg_wdata;
            win_owner = OWN_DBG;
        end else if (dm_gnt_c) begin
            win_we    = bus.dm_we;
            win_addr  = bus.dm_addr;
            win_wdata = bus.dm_wdata;
            win_owner = OWN_DM;
        end
    end

    // Memory command and owner tag advance together so each read return is
    // routed to whoever was granted two cycles earlier.
    always_ff @(posedge clk1) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_valid  <= 1'b0;
            tag1_read   <= 1'b0;
            tag1_owner  <= OWN_IF;
            tag2_valid  <= 1'b0;
            tag2_read   <= 1'b0;
            tag2_owner  <= OWN_IF;
            lock_q      <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            mem_en_q <= any_gnt;
            mem_we_q <= any_gnt & win_we;
            if (any_gnt) begin
                mem_addr_q  <= win_addr;
                mem_wdata_q <= win_wdata;
            end
            tag1_valid <= any_gnt;
            tag1_read  <= ~win_we;
            tag1_owner <= win_owner;
            tag2_valid <= tag1_valid;
            tag2_read  <= tag1_read;
            tag2_owner <= tag1_owner;

            if (!bus.dbg_req)   lock_q <= 1'b0;
            else if (dbg_gnt_c) lock_q <= bus.dbg_lock;

            if (!bus.if_req || halted || if_gnt_c) starve_cnt <= '0;
            else if (starve_cnt != '1)             starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.dm_gnt    = dm_gnt_c;
    assign bus.dbg_gnt   = dbg_gnt_c;
    assign fetch_stall   = if_act & ~if_gnt_c;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.if_rvalid  = tag2_valid & tag2_read & (tag2_owner == OWN_IF);
    assign bus.dm_rvalid  = tag2_valid & tag2_read & (tag2_owner == OWN_DM);
    assign bus.dbg_rvalid = tag2_valid & tag2_read & (tag2_owner == OWN_DBG);
    assign bus.if_rdata   = bus.if_rvalid  ? bus.mem_rdata : '0;
    assign bus.dm_rdata   = bus.dm_rvalid  ? bus.mem_rdata : '0;
    assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
endmodule
